// File: rtl/sdr_port_arbiter.sv
// Round-robin front end for the SDR SDRAM control FSM: picks which egress FIFO
// the FSM serves next and keeps a saturating count of owed auto-refreshes.
module sdr_port_arbiter #(
    parameter int nr_of_ports     = 4,
    parameter int rfr_period      = 390,
    parameter int rfr_max_pending = 7
) (
    input  logic                   sdram_clk,
    input  logic                   sdram_rst,
    input  logic [nr_of_ports-1:0] fifo_empty_i,
    input  logic                   state_idle,
    input  logic                   cmd_aref,
    input  logic                   fifo_rd_adr,
    input  logic                   fifo_rd_data,
    output logic                   fifo_empty,
    output logic                   refresh_req,
    output logic [nr_of_ports-1:0] fifo_sel,
    output logic [1:0]             fifo_sel_bin,
    output logic [nr_of_ports-1:0] fifo_rd_adr_o,
    output logic [nr_of_ports-1:0] fifo_rd_data_o
);

    localparam int cnt_w = (rfr_period > 2) ? $clog2(rfr_period) : 1;

    typedef enum logic [1:0] {
        st_idle,
        st_busy,
        st_rearb
    } arb_state_t;

    arb_state_t       state_reg, state_next;
    logic [1:0]       grant_reg, grant_next;
    logic [cnt_w-1:0] rfr_cnt_reg;
    logic [2:0]       pending_reg, pending_next;
    logic             refresh_req_reg;
    logic             tick;

    // First non-empty port after 'from', wrapping so that 'from' itself is tried last.
    function automatic logic [1:0] next_port(input logic [1:0] from,
                                             input logic [nr_of_ports-1:0] empty);
        logic [1:0] res;
        int         idx;
        res = from;
        for (int k = nr_of_ports - 1; k >= 1; k--) begin
            idx = (int'(from) + k) % nr_of_ports;
            if (!empty[idx]) res = 2'(idx);
        end
        return res;
    endfunction

    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            state_reg <= st_busy;
            grant_reg <= 2'd0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        fifo_empty = fifo_empty_i[grant_reg];
        case (state_reg)
            st_idle: begin
                if (!state_idle)
                    state_next = st_busy;
                else if (fifo_empty_i[grant_reg])
                    grant_next = next_port(grant_reg, fifo_empty_i);
            end
            st_busy: begin
                if (state_idle) state_next = st_rearb;
            end
            st_rearb: begin
                // Hide the old port's flag while the grant moves on.
                fifo_empty = 1'b1;
                grant_next = next_port(grant_reg, fifo_empty_i);
                state_next = st_idle;
            end
            default: state_next = st_busy;
        endcase
    end

    generate
        for (genvar gi = 0; gi < nr_of_ports; gi++) begin : g_port
            assign fifo_sel[gi]       = (grant_reg == 2'(gi));
            assign fifo_rd_adr_o[gi]  = fifo_rd_adr & fifo_sel[gi];
            assign fifo_rd_data_o[gi] = fifo_rd_data & fifo_sel[gi];
        end
    endgenerate

    assign fifo_sel_bin = grant_reg;

    assign tick = (rfr_cnt_reg == cnt_w'(rfr_period - 1));

    always_comb begin
        pending_next = pending_reg;
        if (tick && !cmd_aref) begin
            if (pending_reg != 3'(rfr_max_pending)) pending_next = pending_reg + 3'd1;
        end else if (cmd_aref && !tick) begin
            // Acks issued by the init sequence arrive with nothing pending.
            if (pending_reg != 3'd0) pending_next = pending_reg - 3'd1;
        end
    end

    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            rfr_cnt_reg     <= '0;
            pending_reg     <= 3'd0;
            refresh_req_reg <= 1'b0;
        end else begin
            rfr_cnt_reg     <= tick ? '0 : rfr_cnt_reg + cnt_w'(1);
            pending_reg     <= pending_next;
            refresh_req_reg <= (pending_reg != 3'd0);
        end
    end

    assign refresh_req = refresh_req_reg;

endmodule

// File: tb/tb_sdr_port_arbiter.sv
// Directed vector table for the grant logic plus hand-timed refresh and reset sequences.
module tb_sdr_port_arbiter;

    logic       sdram_clk = 1'b0;
    logic       sdram_rst = 1'b1;
    logic [3:0] fifo_empty_i = 4'hF;
    logic       state_idle = 1'b0;
    logic       cmd_aref = 1'b0;
    logic       fifo_rd_adr = 1'b0;
    logic       fifo_rd_data = 1'b0;
    logic       fifo_empty;
    logic       refresh_req;
    logic [3:0] fifo_sel;
    logic [1:0] fifo_sel_bin;
    logic [3:0] fifo_rd_adr_o;
    logic [3:0] fifo_rd_data_o;

    int total = 0;
    int bad = 0;

    sdr_port_arbiter #(
        .nr_of_ports(4),
        .rfr_period(8),
        .rfr_max_pending(7)
    ) dut (
        .sdram_clk(sdram_clk),
        .sdram_rst(sdram_rst),
        .fifo_empty_i(fifo_empty_i),
        .state_idle(state_idle),
        .cmd_aref(cmd_aref),
        .fifo_rd_adr(fifo_rd_adr),
        .fifo_rd_data(fifo_rd_data),
        .fifo_empty(fifo_empty),
        .refresh_req(refresh_req),
        .fifo_sel(fifo_sel),
        .fifo_sel_bin(fifo_sel_bin),
        .fifo_rd_adr_o(fifo_rd_adr_o),
        .fifo_rd_data_o(fifo_rd_data_o)
    );

    always #5 sdram_clk = ~sdram_clk;

    typedef struct {
        logic       si;
        logic [3:0] emp;
        logic       adr;
        logic       dat;
        logic [3:0] sel;
        logic       fe;
        logic [3:0] adr_o;
        logic [3:0] dat_o;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic si, input logic [3:0] emp, input logic adr, input logic dat,
                       input logic [3:0] sel, input logic fe);
        vec_t v;
        v.si = si; v.emp = emp; v.adr = adr; v.dat = dat;
        v.sel = sel; v.fe = fe;
        v.adr_o = adr ? sel : 4'b0000;
        v.dat_o = dat ? sel : 4'b0000;
        vecs.push_back(v);
    endtask

    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge sdram_clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into cycle 0 after reset release.
    task automatic do_reset();
        sdram_rst = 1'b1;
        cmd_aref = 1'b0; state_idle = 1'b0; fifo_empty_i = 4'hF;
        fifo_rd_adr = 1'b0; fifo_rd_data = 1'b0;
        repeat (2) @(posedge sdram_clk);
        #1;
        sdram_rst = 1'b0;
    endtask

    initial begin
        // Reset, FSM busy 10 cycles, then one REARB with every port empty.
        for (int i = 0; i < 10; i++) add(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1);
        // Four transactions with all ports busy: grants 0,1,2,3 then 0.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 5; i++) add(1'b0, 4'b0000, 1'b0, 1'b0, 4'(1 << t), 1'b0);
            add(1'b1, 4'b0000, 1'b0, 1'b0, 4'(1 << t), 1'b0);
            add(1'b1, 4'b0000, 1'b0, 1'b0, 4'(1 << t), 1'b1);
        end
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0);
        // Re-arbitrate with all empty, then idle-time hop from port 0 to port 1.
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1);
        add(1'b1, 4'b0101, 1'b0, 1'b0, 4'b0001, 1'b1);
        add(1'b0, 4'b0101, 1'b0, 1'b0, 4'b0010, 1'b0);
        add(1'b0, 4'b0111, 1'b0, 1'b0, 4'b0010, 1'b1);
        add(1'b0, 4'b0111, 1'b0, 1'b0, 4'b0010, 1'b1);
        // Move to port 2; strobes follow the grant in REARB, IDLE and BUSY.
        add(1'b1, 4'b1011, 1'b0, 1'b0, 4'b0010, 1'b1);
        add(1'b1, 4'b1011, 1'b1, 1'b0, 4'b0010, 1'b1);
        add(1'b1, 4'b1011, 1'b0, 1'b0, 4'b0100, 1'b0);
        add(1'b0, 4'b1011, 1'b1, 1'b1, 4'b0100, 1'b0);
        add(1'b0, 4'b1011, 1'b0, 1'b1, 4'b0100, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0);

        do_reset();
        chk("reset_refresh_req", 32'(refresh_req), 32'd0);
        chk("reset_sel_bin", 32'(fifo_sel_bin), 32'd0);

        foreach (vecs[i]) begin
            state_idle = vecs[i].si; fifo_empty_i = vecs[i].emp;
            fifo_rd_adr = vecs[i].adr; fifo_rd_data = vecs[i].dat;
            #1;
            chk($sformatf("v%0d_sel", i), 32'(fifo_sel), 32'(vecs[i].sel));
            chk($sformatf("v%0d_sel_bin", i), 32'(fifo_sel_bin), 32'(onehot_idx(vecs[i].sel)));
            chk($sformatf("v%0d_fifo_empty", i), 32'(fifo_empty), 32'(vecs[i].fe));
            chk($sformatf("v%0d_rd_adr_o", i), 32'(fifo_rd_adr_o), 32'(vecs[i].adr_o));
            chk($sformatf("v%0d_rd_data_o", i), 32'(fifo_rd_data_o), 32'(vecs[i].dat_o));
            next_cycle();
        end

        // Asynchronous reset in BUSY with refreshes owed.
        state_idle = 1'b0; fifo_empty_i = 4'b1011;
        chk("pre_rst_refresh_req", 32'(refresh_req), 32'd1);
        chk("pre_rst_sel", 32'(fifo_sel), 32'b0100);
        #2;
        sdram_rst = 1'b1;
        fifo_rd_adr = 1'b1;
        #1;
        chk("async_rst_sel", 32'(fifo_sel), 32'b0001);
        chk("async_rst_sel_bin", 32'(fifo_sel_bin), 32'd0);
        chk("async_rst_refresh_req", 32'(refresh_req), 32'd0);
        chk("async_rst_fifo_empty", 32'(fifo_empty), 32'd1);
        chk("async_rst_rd_adr_o", 32'(fifo_rd_adr_o), 32'b0001);
        fifo_rd_adr = 1'b0;

        // Refresh: first request at cycle 9, saturation at 7, drain with 7 acks.
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            chk($sformatf("rfr_rise_c%0d", c), 32'(refresh_req), (c >= 9) ? 32'd1 : 32'd0);
            if (c < 9) next_cycle();
        end
        repeat (71) next_cycle();
        chk("rfr_c80", 32'(refresh_req), 32'd1);
        for (int c = 80; c < 87; c++) begin
            cmd_aref = 1'b1;
            next_cycle();
        end
        cmd_aref = 1'b0;
        chk("rfr_drain_c87", 32'(refresh_req), 32'd1);
        next_cycle();
        chk("rfr_drain_c88", 32'(refresh_req), 32'd0);
        next_cycle();
        chk("rfr_retick_c89", 32'(refresh_req), 32'd1);

        // Ack coincident with a tick at pending=2, then acks with nothing pending.
        do_reset();
        repeat (23) next_cycle();
        chk("rfr2_c23", 32'(refresh_req), 32'd1);
        cmd_aref = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        cmd_aref = 1'b0;
        chk("rfr2_tick_ack_c26", 32'(refresh_req), 32'd1);
        next_cycle();
        chk("rfr2_empty_c27", 32'(refresh_req), 32'd0);
        cmd_aref = 1'b1;
        next_cycle();
        next_cycle();
        cmd_aref = 1'b0;
        for (int c = 29; c <= 33; c++) begin
            chk($sformatf("rfr2_floor_c%0d", c), 32'(refresh_req), (c >= 33) ? 32'd1 : 32'd0);
            if (c < 33) next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
